// File: rtl/fm_recv.sv
// FM receive discriminator: counts synchronized carrier rising edges per sample window
// and turns the deviation from CENTER into a squelched, offset-binary 10-bit audio sample.
module fm_recv #(
    parameter int SAMPLE_DIV  = 1000,
    parameter int CENTER      = 100,
    parameter int GAIN        = 2,
    parameter int SQUELCH_MIN = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fm_in,
    output logic [9:0]  audio_out,
    output logic        audio_valid,
    output logic        carrier_ok,
    output logic [15:0] freq_count
);

    localparam int                CW       = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 2;
    localparam logic [CW-1:0]     WIN_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic signed [17:0] CENTER_S = 18'(CENTER);
    localparam logic [15:0]       SQ_MIN   = 16'(SQUELCH_MIN);

    logic          s1_q, s2_q, s3_q;
    logic          edge_pulse;
    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic [15:0]   acc_q, acc_d, acc_inc;
    logic [15:0]   snap_q, snap_d;
    logic          snap_vld_q, snap_vld_d;
    logic          terminal;

    logic signed [17:0] diff;
    logic signed [24:0] scaled;
    logic signed [9:0]  clamp_s;
    logic [9:0]         audio_d;
    logic               ok_d;

    logic [9:0]  audio_q;
    logic        valid_q;
    logic        ok_q;
    logic [15:0] freq_q;

    assign edge_pulse = s2_q & ~s3_q;
    assign terminal   = (win_cnt_q == WIN_LAST);

    always_comb begin
        acc_inc    = (acc_q == 16'hFFFF) ? acc_q : acc_q + 16'(edge_pulse);
        win_cnt_d  = terminal ? '0 : win_cnt_q + CW'(1);
        // The terminal-cycle edge belongs to the closing window, so the fresh window starts at 0.
        acc_d      = terminal ? 16'd0 : acc_inc;
        snap_d     = terminal ? acc_inc : snap_q;
        snap_vld_d = terminal;
    end

    always_comb begin
        diff   = $signed({2'b00, snap_q}) - CENTER_S;
        scaled = $signed({{7{diff[17]}}, diff}) <<< GAIN;
        if (scaled > 25'sd511) begin
            clamp_s = 10'sd511;
        end else if (scaled < -25'sd512) begin
            clamp_s = -10'sd512;
        end else begin
            clamp_s = scaled[9:0];
        end
        ok_d    = (snap_q >= SQ_MIN);
        // Offset binary: adding 512 to a 10-bit two's complement value flips its MSB.
        audio_d = ok_d ? ({~clamp_s[9], clamp_s[8:0]}) : 10'd512;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            win_cnt_q  <= '0;
            acc_q      <= 16'd0;
            snap_q     <= 16'd0;
            snap_vld_q <= 1'b0;
        end else begin
            s1_q       <= fm_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            win_cnt_q  <= win_cnt_d;
            acc_q      <= acc_d;
            snap_q     <= snap_d;
            snap_vld_q <= snap_vld_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_q <= 10'd512;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            freq_q  <= 16'd0;
        end else begin
            valid_q <= snap_vld_q;
            if (snap_vld_q) begin
                audio_q <= audio_d;
                ok_q    <= ok_d;
                freq_q  <= snap_q;
            end
        end
    end

    assign audio_out   = audio_q;
    assign audio_valid = valid_q;
    assign carrier_ok  = ok_q;
    assign freq_count  = freq_q;

endmodule

// File: tb/tb_fm_recv.sv
// Randomized scoreboard bench for fm_recv: an edge-timing model predicts each window's
// count and audio sample; a separate monitor checks every strobe and output hold.
module tb_fm_recv;

    localparam int D = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fm_in = 1'b0;
    logic [9:0]  audio_out;
    logic        audio_valid;
    logic        carrier_ok;
    logic [15:0] freq_count;

    fm_recv #(.SAMPLE_DIV(D), .CENTER(100), .GAIN(2), .SQUELCH_MIN(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fm_in      (fm_in),
        .audio_out  (audio_out),
        .audio_valid(audio_valid),
        .carrier_ok (carrier_ok),
        .freq_count (freq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int audio;
        int ok;
    } exp_t;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   due_q[$];
    int   t = 0;
    int   strobes = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, req, t);
        end
    endtask

    function automatic exp_t predict(input int n);
        exp_t e;
        int   s;
        e.n = n;
        if (n < 10) begin
            e.ok    = 0;
            e.audio = 512;
        end else begin
            s = (n - 100) * 4;
            if (s > 511) s = 511;
            if (s < -512) s = -512;
            e.ok    = 1;
            e.audio = s + 512;
        end
        return e;
    endfunction

    // Reference model: a rise sampled at edge k is counted at edge k+2; window w closes at edge (w+1)*D.
    initial begin
        int prev;
        int n;
        prev = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                t    = 0;
                prev = 0;
                due_q.delete();
                exp_q.delete();
            end else begin
                t++;
                if (fm_in && prev == 0) due_q.push_back(t + 2);
                prev = int'(fm_in);
                if (t % D == 0) begin
                    n = 0;
                    while (due_q.size() > 0 && due_q[0] <= t) begin
                        void'(due_q.pop_front());
                        n++;
                    end
                    exp_q.push_back(predict(n));
                end
            end
        end
    end

    // Monitor: every strobe pops the scoreboard; between strobes outputs must hold.
    initial begin
        exp_t last;
        exp_t e;
        int   prev_valid;
        last.n = 0; last.audio = 512; last.ok = 0;
        prev_valid = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                last.n = 0; last.audio = 512; last.ok = 0;
                prev_valid = 0;
            end else begin
                if (audio_valid) begin
                    strobes++;
                    check("strobe_phase", int'((t % D == 1) && (t > D)), 1);
                    check("strobe_gap", prev_valid, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("freq_count", int'(freq_count), e.n);
                        check("audio_out", int'(audio_out), e.audio);
                        check("carrier_ok", int'(carrier_ok), e.ok);
                        $display("sample t=%0d N=%0d audio=%0d ok=%0d", t, freq_count, audio_out, carrier_ok);
                        last = e;
                    end
                end else begin
                    check("hold_audio", int'(audio_out), last.audio);
                    check("hold_freq", int'(freq_count), last.n);
                    check("hold_ok", int'(carrier_ok), last.ok);
                end
                prev_valid = int'(audio_valid);
            end
        end
    end

    task automatic drive(input int period, input int high, input int cycles);
        int ph;
        ph = 0;
        repeat (cycles) begin
            @(negedge clk);
            fm_in = (period > 0) && (ph < high);
            if (period > 0) ph = (ph + 1) % period;
        end
    endtask

    task automatic wait_mod(input int r);
        do @(negedge clk); while (t % D != r);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_audio"}, int'(audio_out), 512);
        check({tag, "_valid"}, int'(audio_valid), 0);
        check({tag, "_ok"}, int'(carrier_ok), 0);
        check({tag, "_freq"}, int'(freq_count), 0);
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int h;
        int ph;
        rst_n = 1'b0;
        fm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        drive(10, 5, 2 * D);     // zero deviation
        drive(8, 4, 2 * D);      // +deviation
        drive(20, 10, 2 * D);    // -deviation
        drive(4, 2, 2 * D);      // clamp high
        drive(200, 100, 2 * D);  // squelched
        drive(100, 50, 2 * D);   // squelch boundary N=10
        drive(0, 0, 2 * D);      // no carrier

        repeat (4) begin
            p = int'($urandom_range(4, 150));
            h = int'($urandom_range(2, p - 2));
            drive(p, h, D + int'($urandom_range(0, D)));
        end

        // Rise counted in the terminal cycle, then one counted just after the boundary.
        fm_in = 1'b0;
        drive(0, 0, D);
        wait_mod(D - 3);
        fm_in = 1'b1;
        drive(3, 3, 2);
        fm_in = 1'b0;
        drive(0, 0, 1);
        wait_mod(D - 2);
        fm_in = 1'b1;
        drive(3, 3, 2);
        fm_in = 1'b0;
        drive(0, 0, 2 * D);

        // Reset in the middle of a window while the carrier keeps running.
        ph = 0;
        do begin
            @(negedge clk);
            fm_in = (ph < 5);
            ph = (ph + 1) % 10;
        end while (t % D != 500);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        drive(10, 5, 3);
        rst_n = 1'b1;
        drive(10, 5, 3 * D + 10);

        drive(0, 0, 5);
        check("scoreboard_empty", exp_q.size(), 0);
        check("strobes_seen_nonzero", int'(strobes > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
